// File: rtl/branch_redirect_unit.sv
// ID-stage branch redirect unit: forms absolute branch/jump targets, applies static
// prediction, and redirects fetch after the delay slot when fetch guessed wrong.
module branch_redirect_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [ADDR_WIDTH-1:0] id_pc,
    input  logic                  is_branch,
    input  logic                  is_jump,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  if_pred_taken,
    input  logic [ADDR_WIDTH-1:0] if_pred_target,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  br_valid,
    output logic                  br_pred_taken,
    output logic [ADDR_WIDTH-1:0] br_pred_target,
    output logic [CNT_WIDTH-1:0]  redirect_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DSLOT = 2'd1,
        REDIRECT   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_INC4 = {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [ADDR_WIDTH-1:0] PC_INC8 = {{(ADDR_WIDTH-4){1'b0}}, 4'b1000};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                state_r;
    logic                  consume_s;
    logic                  pred_taken_s;
    logic                  mismatch_s;
    logic [ADDR_WIDTH-1:0] pc4_s;
    logic [ADDR_WIDTH-1:0] calc_tgt_s;
    logic [ADDR_WIDTH-1:0] pred_tgt_s;

    // Target formation, static prediction and fetch-prediction comparison.
    always_comb begin
        id_ready  = 1'b0;
        pc4_s     = id_pc + PC_INC4;
        if (flush) begin
            id_ready = 1'b0;
        end else if (state_r == REDIRECT) begin
            id_ready = 1'b0;
        end else begin
            id_ready = 1'b1;
        end
        consume_s = id_valid & id_ready;

        // Jumps keep the 256MB region of the delay slot; branches are PC-relative.
        if (is_jump) begin
            calc_tgt_s   = {pc4_s[ADDR_WIDTH-1:ADDR_WIDTH-4], target[ADDR_WIDTH-5:0]};
            pred_taken_s = 1'b1;
        end else begin
            calc_tgt_s   = pc4_s + target;
            pred_taken_s = target[ADDR_WIDTH-1];
        end

        if (pred_taken_s) begin
            pred_tgt_s = calc_tgt_s;
        end else begin
            pred_tgt_s = id_pc + PC_INC8;
        end

        if (pred_taken_s != if_pred_taken) begin
            mismatch_s = 1'b1;
        end else if (pred_taken_s && (calc_tgt_s != if_pred_target)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Redirect FSM, registered prediction info and saturating redirect counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= {ADDR_WIDTH{1'b0}};
            br_valid       <= 1'b0;
            br_pred_taken  <= 1'b0;
            br_pred_target <= {ADDR_WIDTH{1'b0}};
            redirect_count <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            state_r        <= IDLE;
            redirect_valid <= 1'b0;
            br_valid       <= 1'b0;
        end else begin
            br_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (consume_s && is_branch) begin
                        br_valid       <= 1'b1;
                        br_pred_taken  <= pred_taken_s;
                        br_pred_target <= pred_tgt_s;
                        if (mismatch_s) begin
                            redirect_pc <= pred_tgt_s;
                            state_r     <= WAIT_DSLOT;
                        end
                    end
                end
                // Whatever arrives next is the delay slot, branch or not.
                WAIT_DSLOT: begin
                    if (consume_s) begin
                        state_r        <= REDIRECT;
                        redirect_valid <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state_r        <= IDLE;
                        redirect_valid <= 1'b0;
                        if (redirect_count != CNT_MAX) begin
                            redirect_count <= redirect_count + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic
// checked every cycle against a behavioural model of the redirect unit.
module tb_branch_redirect_unit;

    localparam int AW   = 32;
    localparam int CW   = 3;
    localparam int CMAX = 7;

    logic          clk = 1'b0;
    logic          rst, flush, id_valid, id_ready, is_branch, is_jump;
    logic [AW-1:0] id_pc, target, if_pred_target, redirect_pc, br_pred_target;
    logic          if_pred_taken, redirect_valid, redirect_ready, br_valid, br_pred_taken;
    logic [CW-1:0] redirect_count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state
    bit            m_rv, m_bv, m_bt, m_wait_ds;
    logic [31:0]   m_rpc, m_btgt;
    int            m_cnt;

    branch_redirect_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .is_branch(is_branch), .is_jump(is_jump), .target(target),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .br_valid(br_valid), .br_pred_taken(br_pred_taken),
        .br_pred_target(br_pred_target), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // {predicted taken, predicted next PC} from the static rules
    function automatic logic [32:0] static_pred(input logic [31:0] pc, input logic [31:0] tgt,
                                                input bit jmp);
        logic [31:0] nxt;
        nxt = pc + 32'd4;
        if (jmp) return {1'b1, (nxt & 32'hF000_0000) | (tgt & 32'h0FFF_FFFF)};
        if (tgt[31]) return {1'b1, nxt + tgt};
        return {1'b0, pc + 32'd8};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: advances on each clock edge from the inputs the DUT saw
    always @(posedge clk) begin
        logic [32:0] p;
        bit          mis;
        if (rst) begin
            m_rv = 0; m_bv = 0; m_bt = 0; m_wait_ds = 0;
            m_rpc = 32'd0; m_btgt = 32'd0; m_cnt = 0;
        end else if (flush) begin
            m_rv = 0; m_bv = 0; m_wait_ds = 0;
        end else begin
            m_bv = 0;
            if (m_rv) begin
                if (redirect_ready) begin
                    m_rv = 0;
                    if (m_cnt < CMAX) m_cnt++;
                end
            end else if (id_valid) begin
                if (m_wait_ds) begin
                    m_wait_ds = 0;
                    m_rv = 1;
                end else if (is_branch) begin
                    p = static_pred(id_pc, target, is_jump);
                    mis = (p[32] != if_pred_taken) || (p[32] && p[31:0] != if_pred_target);
                    m_bv = 1; m_bt = p[32]; m_btgt = p[31:0];
                    if (mis) begin
                        m_rpc = p[31:0];
                        m_wait_ds = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("id_ready", {31'd0, id_ready}, {31'd0, !m_rv && !flush});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("br_valid", {31'd0, br_valid}, {31'd0, m_bv});
            chk("br_pred_taken", {31'd0, br_pred_taken}, {31'd0, m_bt});
            chk("br_pred_target", br_pred_target, m_btgt);
            chk("redirect_count", {29'd0, redirect_count}, m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        flush = 0; id_valid = 0; is_branch = 0; is_jump = 0; id_pc = 32'd0;
        target = 32'd0; if_pred_taken = 0; if_pred_target = 32'd0; redirect_ready = 0;
    endtask

    task automatic put_br(input logic [31:0] pc, input logic [31:0] tgt, input bit jmp,
                          input bit ptk, input logic [31:0] ptg);
        idle_in();
        id_valid = 1; is_branch = 1; is_jump = jmp; id_pc = pc; target = tgt;
        if_pred_taken = ptk; if_pred_target = ptg;
    endtask

    task automatic put_slot(input logic [31:0] pc);
        idle_in();
        id_valid = 1; id_pc = pc;
    endtask

    initial begin
        logic [32:0] p;
        idle_in();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        chk_en = 1;
        cyc();
        chk("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset br_valid", {31'd0, br_valid}, 32'd0);
        chk("reset count", {29'd0, redirect_count}, 32'd0);
        chk("reset id_ready", {31'd0, id_ready}, 32'd1);

        // Backward BEQ predicted not-taken by fetch
        put_br(32'h0000_1000, 32'hFFFF_FFF0, 0, 0, 32'd0);
        cyc();
        chk("beq br_valid", {31'd0, br_valid}, 32'd1);
        chk("beq br_pred_taken", {31'd0, br_pred_taken}, 32'd1);
        chk("beq br_pred_target", br_pred_target, 32'h0000_0FF4);
        chk("beq early rv", {31'd0, redirect_valid}, 32'd0);
        put_slot(32'h0000_1004);
        cyc();
        chk("beq rv", {31'd0, redirect_valid}, 32'd1);
        chk("beq redirect_pc", redirect_pc, 32'h0000_0FF4);
        idle_in();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("beq hold id_ready", {31'd0, id_ready}, 32'd0);
            chk("beq hold pc", redirect_pc, 32'h0000_0FF4);
        end
        redirect_ready = 1;
        cyc();
        chk("beq count", {29'd0, redirect_count}, 32'd1);
        chk("beq rv drop", {31'd0, redirect_valid}, 32'd0);
        idle_in();

        // J correctly predicted
        put_br(32'h8000_0000, 32'h0040_0000, 1, 1, 32'h8040_0000);
        cyc();
        chk("j br_valid", {31'd0, br_valid}, 32'd1);
        chk("j br_pred_target", br_pred_target, 32'h8040_0000);
        put_slot(32'h8000_0004);
        cyc();
        chk("j br_valid pulse", {31'd0, br_valid}, 32'd0);
        idle_in();
        cyc();
        chk("j no redirect", {31'd0, redirect_valid}, 32'd0);

        // Forward branch predicted taken by fetch, then flush during REDIRECT
        put_br(32'h0000_2000, 32'h0000_0010, 0, 1, 32'h0000_2014);
        cyc();
        chk("fwd br_pred_taken", {31'd0, br_pred_taken}, 32'd0);
        put_slot(32'h0000_2004);
        cyc();
        chk("fwd redirect_pc", redirect_pc, 32'h0000_2008);
        idle_in();
        flush = 1; redirect_ready = 1;
        #1 chk("flush id_ready", {31'd0, id_ready}, 32'd0);
        cyc();
        chk("flush rv", {31'd0, redirect_valid}, 32'd0);
        chk("flush count", {29'd0, redirect_count}, 32'd1);

        // Flush while waiting for the delay slot
        put_br(32'h0000_2000, 32'h0000_0010, 0, 1, 32'h0000_2014);
        cyc();
        idle_in(); flush = 1;
        cyc();
        put_slot(32'h0000_2004);
        cyc();
        idle_in();
        cyc();
        chk("flush wait rv", {31'd0, redirect_valid}, 32'd0);

        // Fall-through wraps past the top of the address space
        put_br(32'hFFFF_FFF8, 32'h0000_0008, 0, 1, 32'h0000_0004);
        cyc();
        chk("wrap br_pred_taken", {31'd0, br_pred_taken}, 32'd0);
        put_slot(32'hFFFF_FFFC);
        cyc();
        chk("wrap redirect_pc", redirect_pc, 32'h0000_0000);
        idle_in(); redirect_ready = 1;
        cyc();
        chk("wrap count", {29'd0, redirect_count}, 32'd2);

        // Reset while a redirect is pending
        put_br(32'h0000_1000, 32'hFFFF_FFF0, 0, 0, 32'd0);
        cyc();
        put_slot(32'h0000_1004);
        cyc();
        idle_in(); rst = 1;
        cyc();
        rst = 0;
        chk("rst rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'd0);
        chk("rst br_pred_target", br_pred_target, 32'd0);
        chk("rst count", {29'd0, redirect_count}, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            idle_in();
            rst            = ($urandom_range(199) == 0);
            flush          = ($urandom_range(19) == 0);
            id_valid       = ($urandom_range(9) < 7);
            is_branch      = $urandom_range(1);
            is_jump        = is_branch && ($urandom_range(3) == 0);
            id_pc          = $urandom & 32'hFFFF_FFFC;
            target         = $urandom_range(1) ? ($urandom & 32'hFFFF_FFFC)
                                               : ($urandom_range(255) << 2) - 32'd512;
            p              = static_pred(id_pc, target, is_jump);
            if_pred_taken  = ($urandom_range(2) != 0) ? p[32] : !p[32];
            if_pred_target = $urandom_range(1) ? p[31:0] : $urandom;
            redirect_ready = $urandom_range(1);
            cyc();
        end

        // Saturation of the redirect counter
        idle_in(); rst = 1;
        cyc();
        rst = 0;
        for (int k = 0; k < CMAX + 2; k++) begin
            put_br(32'hFFFF_FFF8, 32'h0000_0008, 0, 1, 32'h0000_0004);
            cyc();
            put_slot(32'hFFFF_FFFC);
            cyc();
            idle_in(); redirect_ready = 1;
            cyc();
            idle_in();
        end
        chk("saturated count", {29'd0, redirect_count}, 32'd7);
        cyc();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
